// File: rtl/ser_arb_pkg.sv
// Shared types and default sizing for the serializer arbiter.
package ser_arb_pkg;

  localparam int DATA_W        = 8;
  localparam int DEF_BURST_LEN = 16;
  localparam int DEF_HOLDOFF   = 24;
  localparam int DEF_TIMEOUT   = 32;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_GRANT  = 2'd1,
    ST_STREAM = 2'd2,
    ST_HOLD   = 2'd3
  } state_t;

endpackage

// File: rtl/serializer_arbiter_rr_picker.sv
// Round-robin picker: first requester above last_owner (wrapping), so the
// previous owner always ends up with the lowest priority.
module rr_picker #(
  parameter int NREQ  = 2,
  parameter int IDX_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0]  i_req,
  input  logic [IDX_W-1:0] i_last,
  output logic             o_any,
  output logic [NREQ-1:0]  o_onehot,
  output logic [IDX_W-1:0] o_idx
);

  logic [IDX_W-1:0] w_cand;
  logic             w_hit;

  // Scan candidates last+1 .. last+NREQ and keep the first one requesting.
  always_comb begin
    o_any    = 1'b0;
    o_onehot = '0;
    o_idx    = '0;
    w_cand   = '0;
    w_hit    = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      w_cand   = IDX_W'((int'(i_last) + k) % NREQ);
      w_hit    = !o_any && i_req[w_cand];
      o_onehot = w_hit ? (NREQ'(1) << w_cand) : o_onehot;
      o_idx    = w_hit ? w_cand : o_idx;
      o_any    = o_any | w_hit;
    end
  end

endmodule

// File: rtl/serializer_arbiter.sv
// Burst arbiter in front of a byte serializer: one owner streams BURST_LEN
// samples, then a HOLDOFF drain gap. Optional GRANT timeout: SER_ARB_TIMEOUT_EN.
module serializer_arbiter
  import ser_arb_pkg::*;
#(
  parameter int NREQ      = 2,
  parameter int BURST_LEN = DEF_BURST_LEN,
  parameter int HOLDOFF   = DEF_HOLDOFF,
  parameter int TIMEOUT   = DEF_TIMEOUT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req,
  input  logic [DATA_W*NREQ-1:0] din,
  input  logic [NREQ-1:0]        din_valid,
  output logic [NREQ-1:0]        gnt,
  output logic [DATA_W-1:0]      ser_din,
  output logic                   ser_din_valid,
  output logic                   busy,
  output logic                   err_short,
  output logic                   err_timeout
);

  localparam int IDX_W  = $clog2(NREQ);
  localparam int CNT_W  = $clog2(BURST_LEN + 1);
  localparam int HOLD_W = $clog2(HOLDOFF + 1);

  if (NREQ < 2 || NREQ > 8 || BURST_LEN < 1 || HOLDOFF < 1 || TIMEOUT < 1) begin : g_bad_cfg
    $error("serializer_arbiter: parameter out of range");
  end

  state_t              r_state;
  logic [IDX_W-1:0]    r_last_owner;
  logic [NREQ-1:0]     r_gnt;
  logic [DATA_W-1:0]   r_ser_din;
  logic                r_ser_valid;
  logic                r_busy;
  logic                r_err_short;
  logic [CNT_W-1:0]    r_cnt;
  logic [HOLD_W-1:0]   r_hold_cnt;

  logic                w_pick_any;
  logic [NREQ-1:0]     w_pick_onehot;
  logic [IDX_W-1:0]    w_pick_idx;
  logic                w_own_valid;
  logic                w_own_req;
  logic [DATA_W-1:0]   w_own_data;
  logic                w_last_sample;
  logic                w_to_hit;

  rr_picker #(.NREQ(NREQ), .IDX_W(IDX_W)) u_picker (
    .i_req    (req),
    .i_last   (r_last_owner),
    .o_any    (w_pick_any),
    .o_onehot (w_pick_onehot),
    .o_idx    (w_pick_idx)
  );

  // r_last_owner doubles as the current owner once a grant is issued.
  assign w_own_valid   = din_valid[r_last_owner];
  assign w_own_req     = req[r_last_owner];
  assign w_own_data    = din[DATA_W*int'(r_last_owner) +: DATA_W];
  assign w_last_sample = (r_cnt == CNT_W'(BURST_LEN - 1));

`ifdef SER_ARB_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT + 1);
  logic [TO_W-1:0] r_to_cnt;
  logic            r_err_timeout;

  assign w_to_hit = (r_state == ST_GRANT) && !w_own_valid && w_own_req &&
                    (r_to_cnt == TO_W'(TIMEOUT - 1));

  // Cycles spent in GRANT waiting for the owner's first sample.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_to_cnt      <= '0;
      r_err_timeout <= 1'b0;
    end else begin
      r_err_timeout <= w_to_hit;
      if (r_state == ST_GRANT && !w_own_valid && !w_to_hit) begin
        r_to_cnt <= r_to_cnt + TO_W'(1);
      end else begin
        r_to_cnt <= '0;
      end
    end
  end

  assign err_timeout = r_err_timeout;
`else
  assign w_to_hit    = 1'b0;
  assign err_timeout = 1'b0;
`endif

  // Arbitration FSM with registered grant, datapath and status outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= ST_IDLE;
      r_last_owner <= IDX_W'(NREQ - 1);
      r_gnt        <= '0;
      r_ser_din    <= '0;
      r_ser_valid  <= 1'b0;
      r_busy       <= 1'b0;
      r_err_short  <= 1'b0;
      r_cnt        <= '0;
      r_hold_cnt   <= '0;
    end else begin
      r_err_short <= 1'b0;
      r_ser_valid <= 1'b0;
      r_ser_din   <= '0;
      case (r_state)
        ST_IDLE: begin
          r_cnt      <= '0;
          r_hold_cnt <= '0;
          if (w_pick_any) begin
            r_state      <= ST_GRANT;
            r_gnt        <= w_pick_onehot;
            r_last_owner <= w_pick_idx;
            r_busy       <= 1'b1;
          end else begin
            r_gnt  <= '0;
            r_busy <= 1'b0;
          end
        end
        ST_GRANT, ST_STREAM: begin
          if (w_own_valid) begin
            r_ser_din   <= w_own_data;
            r_ser_valid <= 1'b1;
            r_cnt       <= r_cnt + CNT_W'(1);
            if (w_last_sample) begin
              r_state <= ST_HOLD;
              r_gnt   <= '0;
            end else begin
              r_state <= ST_STREAM;
            end
          end else if (r_state == ST_STREAM) begin
            r_err_short <= 1'b1;
            r_state     <= ST_HOLD;
            r_gnt       <= '0;
          end else if (!w_own_req || w_to_hit) begin
            r_state <= ST_IDLE;
            r_gnt   <= '0;
            r_busy  <= 1'b0;
          end else begin
            r_state <= ST_GRANT;
          end
        end
        ST_HOLD: begin
          r_gnt <= '0;
          if (r_hold_cnt == HOLD_W'(HOLDOFF - 1)) begin
            r_state    <= ST_IDLE;
            r_busy     <= 1'b0;
            r_hold_cnt <= '0;
          end else begin
            r_hold_cnt <= r_hold_cnt + HOLD_W'(1);
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_gnt   <= '0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign gnt           = r_gnt;
  assign ser_din       = r_ser_din;
  assign ser_din_valid = r_ser_valid;
  assign busy          = r_busy;
  assign err_short     = r_err_short;

endmodule

// File: tb/tb_serializer_arbiter.sv
// Directed bench for serializer_arbiter (default parameters, NREQ=2).
module tb_serializer_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req;
  logic [15:0] din;
  logic [1:0]  din_valid;
  logic [1:0]  gnt;
  logic [7:0]  ser_din;
  logic        ser_din_valid;
  logic        busy;
  logic        err_short;
  logic        err_timeout;

  int checks   = 0;
  int failures = 0;

  serializer_arbiter dut (
    .clk           (clk),
    .rst           (rst),
    .req           (req),
    .din           (din),
    .din_valid     (din_valid),
    .gnt           (gnt),
    .ser_din       (ser_din),
    .ser_din_valid (ser_din_valid),
    .busy          (busy),
    .err_short     (err_short),
    .err_timeout   (err_timeout)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog expired before end of test");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Owner presents v; the other requester presents junk that must be ignored.
  task automatic drive_sample(input int who, input logic [7:0] v);
    din_valid            = 2'b11;
    din[8*who +: 8]      = v;
    din[8*(1-who) +: 8]  = 8'h5A;
  endtask

  // Wait for the grant to 'owner', stream n samples, then measure the hold gap.
  task automatic run_burst(input int owner, input logic [7:0] base, input int n, input bit full);
    int  waited = 0;
    int  h = 0;
    bit  two_hot = 1'b0;
    bit  noise = 1'b0;
    din_valid = 2'b00;
    while (gnt == 2'b00 && waited < 200) begin
      tick();
      waited++;
      if ($countones(gnt) > 1) two_hot = 1'b1;
    end
    chk("grant_owner", 32'(gnt), 32'(2'b01 << owner));
    for (int i = 0; i < n; i++) begin
      drive_sample(owner, base + 8'(i));
      tick();
      chk("ser_din", 32'(ser_din), 32'(base + 8'(i)));
      chk("ser_valid", 32'(ser_din_valid), 32'd1);
      chk("gnt_during", 32'(gnt), (full && i == n - 1) ? 32'd0 : 32'(2'b01 << owner));
    end
    if (full) begin
      drive_sample(owner, 8'hFF);
    end else begin
      din_valid = 2'b00;
    end
    tick();
    din_valid = 2'b00;
    chk("post_valid", 32'(ser_din_valid), 32'd0);
    chk("post_din", 32'(ser_din), 32'd0);
    chk("err_short", 32'(err_short), full ? 32'd0 : 32'd1);
    chk("post_gnt", 32'(gnt), 32'd0);
    chk("post_busy", 32'(busy), 32'd1);
    while (busy && h < 200) begin
      tick();
      h++;
      if (err_short || ser_din_valid || gnt != 2'b00 || ser_din != 8'h00) noise = 1'b1;
      if ($countones(gnt) > 1) two_hot = 1'b1;
    end
    chk("hold_len", 32'(h), full ? 32'd23 : 32'd24);
    chk("hold_quiet", 32'(noise), 32'd0);
    chk("two_hot", 32'(two_hot), 32'd0);
  endtask

  initial begin
    bit bad;
    rst       = 1'b0;
    req       = 2'b00;
    din       = 16'h0000;
    din_valid = 2'b00;
    #12;
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_ser_din", 32'(ser_din), 32'd0);
    chk("rst_ser_valid", 32'(ser_din_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_err_short", 32'(err_short), 32'd0);
    chk("rst_err_timeout", 32'(err_timeout), 32'd0);
    tick();
    rst = 1'b1;
    tick();

    // Single requester, full 16-sample burst followed by the drain gap.
    req = 2'b01;
    run_burst(0, 8'h10, 16, 1'b1);
    req = 2'b00;

    // Both requesting from a fresh reset: bursts go 0, 1, 0.
    tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    req = 2'b11;
    run_burst(0, 8'h20, 16, 1'b1);
    run_burst(1, 8'h30, 16, 1'b1);
    run_burst(0, 8'h40, 16, 1'b1);
    req = 2'b00;

    // Short burst from requester 1.
    req = 2'b10;
    run_burst(1, 8'hA0, 5, 1'b0);
    req = 2'b00;

    // Request withdrawn in GRANT: silent return to IDLE, owner still rotates.
    req = 2'b01;
    tick();
    chk("drop_gnt0", 32'(gnt), 32'h1);
    req = 2'b00;
    tick();
    chk("drop_gnt", 32'(gnt), 32'd0);
    chk("drop_busy", 32'(busy), 32'd0);
    chk("drop_valid", 32'(ser_din_valid), 32'd0);
    chk("drop_err", 32'(err_short), 32'd0);
    req = 2'b11;
    tick();
    chk("drop_rotate", 32'(gnt), 32'h2);
    req = 2'b00;
    tick();
    chk("drop_idle", 32'(busy), 32'd0);

    // Reset during the 8th sample, then requester 0 wins again.
    req = 2'b11;
    tick();
    chk("mid_gnt", 32'(gnt), 32'h1);
    for (int i = 0; i < 8; i++) begin
      drive_sample(0, 8'h50 + 8'(i));
      tick();
      chk("mid_valid", 32'(ser_din_valid), 32'd1);
    end
    #2;
    rst = 1'b0;
    #1;
    din_valid = 2'b00;
    chk("arst_gnt", 32'(gnt), 32'd0);
    chk("arst_ser_din", 32'(ser_din), 32'd0);
    chk("arst_valid", 32'(ser_din_valid), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_err", 32'(err_short), 32'd0);
    #2;
    rst = 1'b1;
    tick();
    chk("rel_gnt", 32'(gnt), 32'h1);
    chk("rel_err", 32'(err_short), 32'd0);

    // Grant held with req but no valid.
    bad = 1'b0;
`ifdef SER_ARB_TIMEOUT_EN
    for (int i = 0; i < 31; i++) begin
      tick();
      if (gnt != 2'b01 || err_timeout) bad = 1'b1;
    end
    chk("to_hold", 32'(bad), 32'd0);
    tick();
    chk("to_gnt", 32'(gnt), 32'd0);
    chk("to_pulse", 32'(err_timeout), 32'd1);
    tick();
    chk("to_next", 32'(gnt), 32'h2);
    chk("to_once", 32'(err_timeout), 32'd0);
`else
    for (int i = 0; i < 40; i++) begin
      tick();
      if (gnt != 2'b01 || err_timeout) bad = 1'b1;
    end
    chk("wait_hold", 32'(bad), 32'd0);
    chk("wait_no_to", 32'(err_timeout), 32'd0);
`endif
    req = 2'b00;
    tick();
    tick();
    chk("end_busy", 32'(busy), 32'd0);
    chk("end_gnt", 32'(gnt), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
